// File: rtl/i2c_pkg.sv
// Shared types and constants for the single-byte I2C master sequencer.
package i2c_pkg;

  // Transfer phases, in the order a transfer walks through them
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_START    = 3'd1,
    ST_ADDR     = 3'd2,
    ST_ADDR_ACK = 3'd3,
    ST_DATA     = 3'd4,
    ST_DATA_ACK = 3'd5,
    ST_STOP     = 3'd6
  } state_t;

  // Quarter index within one SCL bit period
  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  // Bit counter width: counts 7 down to 0, MSB first
  localparam int BIT_W = 3;

  // SCL is pulled low in q0 and q3 of every data/ack bit
  function automatic logic scl_pull_in_bit(input logic [1:0] qtr);
    return (qtr == Q0) || (qtr == Q3);
  endfunction

endpackage

// File: rtl/i2c_qtr_tick.sv
// Quarter-period prescaler: pulses tick once every QTR clock cycles.
module i2c_qtr_tick
  import i2c_pkg::*;
#(
  parameter int QTR = 125
) (
  input  logic PCLK,
  input  logic PRESETn,
  input  logic clr,
  output logic tick
);

  logic [15:0] count_r;

  assign tick = (count_r == 16'(QTR - 1));

  // Free-running quarter counter, held at zero while the controller is idle
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      count_r <= 16'd0;
    end else if (clr) begin
      count_r <= 16'd0;
    end else if (tick) begin
      count_r <= 16'd0;
    end else begin
      count_r <= count_r + 16'd1;
    end
  end

endmodule

// File: rtl/i2c_master_ctrl.sv
// Single-byte I2C master: START, address byte, one data byte (write or read), STOP.
// Line drives are computed for the quarter being entered and registered, so
// scl_oe/sda_oe only move on quarter boundaries.
module i2c_master_ctrl
  import i2c_pkg::*;
#(
  parameter int dataWidth = 32,
  parameter int QTR       = 125
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  input  logic                 startbit,
  input  logic                 resetbit,
  input  logic                 it_enable,
  input  logic [dataWidth-1:0] per_addr,
  input  logic [dataWidth-1:0] per_data,
  input  logic                 sda_i,
  output logic                 scl_oe,
  output logic                 sda_oe,
  output logic                 busy,
  output logic                 done,
  output logic                 ack_err,
  output logic [7:0]           rx_data,
  output logic                 irq
);

  state_t           state_r, state_n;
  logic [1:0]       qtr_r, qtr_n;
  logic [BIT_W-1:0] bit_r, bit_n;
  logic             tick_s, start_acc_s, finish_s, sample_s, read_done_s;
  logic             scl_n_s, sda_n_s;
  logic [7:0]       addr_r, data_r, shift_r;
  logic             scl_oe_r, sda_oe_r, busy_r, done_r, ack_err_r, irq_r;
  logic [7:0]       rx_data_r;
  logic             unused_s;

  // Only the low byte of each APB register is meaningful
  assign unused_s = ^{per_addr[dataWidth-1:8], per_data[dataWidth-1:8]};

  i2c_qtr_tick #(.QTR(QTR)) u_tick (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .clr     (resetbit | (state_r == ST_IDLE)),
    .tick    (tick_s)
  );

  assign sample_s    = tick_s && (qtr_r == Q2) && !resetbit;
  assign read_done_s = tick_s && (qtr_r == Q3) && (state_r == ST_DATA) &&
                       (bit_r == 3'd0) && addr_r[0] && !resetbit;

  // FSM state, quarter and bit counters
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_r <= ST_IDLE;
      qtr_r   <= Q0;
      bit_r   <= 3'd0;
    end else begin
      state_r <= state_n;
      qtr_r   <= qtr_n;
      bit_r   <= bit_n;
    end
  end

  // Next state: soft reset first, then start acceptance, then quarter stepping
  always_comb begin
    state_n     = state_r;
    qtr_n       = qtr_r;
    bit_n       = bit_r;
    start_acc_s = 1'b0;
    finish_s    = 1'b0;
    if (resetbit) begin
      state_n = ST_IDLE;
      qtr_n   = Q0;
      bit_n   = 3'd0;
    end else if (state_r == ST_IDLE) begin
      if (startbit) begin
        start_acc_s = 1'b1;
        state_n     = ST_START;
        qtr_n       = Q0;
        bit_n       = 3'd0;
      end else begin
        state_n = ST_IDLE;
      end
    end else if (tick_s) begin
      if (qtr_r != Q3) begin
        qtr_n = qtr_r + 2'd1;
      end else begin
        qtr_n = Q0;
        case (state_r)
          ST_START: begin
            state_n = ST_ADDR;
            bit_n   = 3'd7;
          end
          ST_ADDR: begin
            if (bit_r == 3'd0) state_n = ST_ADDR_ACK;
            else               bit_n   = bit_r - 3'd1;
          end
          ST_ADDR_ACK: begin
            // ack_err was sampled in q2 of this bit and is still clear unless NACKed
            if (ack_err_r) begin
              state_n = ST_STOP;
            end else begin
              state_n = ST_DATA;
              bit_n   = 3'd7;
            end
          end
          ST_DATA: begin
            if (bit_r == 3'd0) state_n = ST_DATA_ACK;
            else               bit_n   = bit_r - 3'd1;
          end
          ST_DATA_ACK: state_n = ST_STOP;
          ST_STOP: begin
            state_n  = ST_IDLE;
            finish_s = 1'b1;
          end
          default: state_n = ST_IDLE;
        endcase
      end
    end else begin
      state_n = state_r;
    end
  end

  // Line drive for the quarter about to be entered
  always_comb begin
    scl_n_s = 1'b0;
    sda_n_s = 1'b0;
    case (state_n)
      ST_IDLE: begin
        scl_n_s = 1'b0;
        sda_n_s = 1'b0;
      end
      ST_START: begin
        scl_n_s = (qtr_n == Q3);
        sda_n_s = (qtr_n == Q2) || (qtr_n == Q3);
      end
      ST_ADDR: begin
        scl_n_s = scl_pull_in_bit(qtr_n);
        sda_n_s = ~addr_r[bit_n];
      end
      ST_ADDR_ACK, ST_DATA_ACK: begin
        scl_n_s = scl_pull_in_bit(qtr_n);
        sda_n_s = 1'b0;
      end
      ST_DATA: begin
        scl_n_s = scl_pull_in_bit(qtr_n);
        sda_n_s = addr_r[0] ? 1'b0 : ~data_r[bit_n];
      end
      ST_STOP: begin
        scl_n_s = (qtr_n == Q0);
        sda_n_s = (qtr_n == Q0) || (qtr_n == Q1);
      end
      default: begin
        scl_n_s = 1'b0;
        sda_n_s = 1'b0;
      end
    endcase
  end

  // Registered outputs, latched transfer bytes, status and receive shifter
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      scl_oe_r  <= 1'b0;
      sda_oe_r  <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      ack_err_r <= 1'b0;
      irq_r     <= 1'b0;
      rx_data_r <= 8'd0;
      addr_r    <= 8'd0;
      data_r    <= 8'd0;
      shift_r   <= 8'd0;
    end else begin
      scl_oe_r <= scl_n_s;
      sda_oe_r <= sda_n_s;
      done_r   <= finish_s;
      if (resetbit) begin
        busy_r    <= 1'b0;
        ack_err_r <= 1'b0;
        irq_r     <= 1'b0;
      end else if (start_acc_s) begin
        busy_r    <= 1'b1;
        ack_err_r <= 1'b0;
        irq_r     <= 1'b0;
        addr_r    <= per_addr[7:0];
        data_r    <= per_data[7:0];
      end else begin
        if (finish_s) busy_r <= 1'b0;
        if (sample_s && sda_i &&
            ((state_r == ST_ADDR_ACK) || ((state_r == ST_DATA_ACK) && !addr_r[0])))
          ack_err_r <= 1'b1;
        if (sample_s && (state_r == ST_DATA) && addr_r[0])
          shift_r <= {shift_r[6:0], sda_i};
        if (read_done_s) rx_data_r <= shift_r;
        if (!it_enable)    irq_r <= 1'b0;
        else if (finish_s) irq_r <= 1'b1;
      end
    end
  end

  assign scl_oe  = scl_oe_r;
  assign sda_oe  = sda_oe_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign ack_err = ack_err_r;
  assign rx_data = rx_data_r;
  assign irq     = irq_r;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Self-checking bench for i2c_master_ctrl: bus-level slave, SCL-rise bit monitor
// and a transfer-level expectation model.
module tb_i2c_master_ctrl;

  localparam int QTR = 4;

  logic        PCLK = 1'b0;
  logic        PRESETn, startbit, resetbit, it_enable, sda_i;
  logic [31:0] per_addr, per_data;
  logic        scl_oe, sda_oe, busy, done, ack_err, irq;
  logic [7:0]  rx_data;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] data;
    logic [7:0] rbyte;
    logic       ack_a;
    logic       ack_d;
    logic       ien;
    logic       mid;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  logic slave_rel;
  logic s_ack_a, s_ack_d, s_rd;
  logic [7:0] s_byte;
  logic [7:0] exp_rx;
  logic bit_q[$];
  int   fall_cnt, start_cnt, stop_cnt, busy_cnt, done_cnt;
  logic irq_at_done, busy_at_done, prev_scl_oe, prev_sda;
  vec_t tbl[6];

  assign sda_i = ~sda_oe & slave_rel;

  i2c_master_ctrl #(.dataWidth(32), .QTR(QTR)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .startbit(startbit), .resetbit(resetbit),
    .it_enable(it_enable), .per_addr(per_addr), .per_data(per_data), .sda_i(sda_i),
    .scl_oe(scl_oe), .sda_oe(sda_oe), .busy(busy), .done(done), .ack_err(ack_err),
    .rx_data(rx_data), .irq(irq)
  );

  always #5 PCLK = ~PCLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon_clear();
    bit_q.delete();
    fall_cnt = 0; start_cnt = 0; stop_cnt = 0; busy_cnt = 0; done_cnt = 0;
    irq_at_done = 1'b0; busy_at_done = 1'b1;
    slave_rel = 1'b1;
    prev_scl_oe = scl_oe;
    prev_sda = ~sda_oe;
  endtask

  // One clock: observe the bus at the falling PCLK edge and play the slave
  task automatic step();
    logic bus_sda;
    @(negedge PCLK);
    bus_sda = ~sda_oe & slave_rel;
    if (prev_scl_oe && !scl_oe) bit_q.push_back(bus_sda);
    if (!prev_scl_oe && !scl_oe) begin
      if (prev_sda && !bus_sda) start_cnt++;
      if (!prev_sda && bus_sda) stop_cnt++;
    end
    if (!prev_scl_oe && scl_oe) begin
      fall_cnt++;
      if (fall_cnt == 9)
        slave_rel = ~s_ack_a;
      else if (fall_cnt >= 10 && fall_cnt <= 17 && s_ack_a && s_rd)
        slave_rel = s_byte[3'(17 - fall_cnt)];
      else if (fall_cnt == 18 && s_ack_a && !s_rd)
        slave_rel = ~s_ack_d;
      else
        slave_rel = 1'b1;
    end
    if (busy) busy_cnt++;
    if (done) begin
      done_cnt++;
      irq_at_done = irq;
      busy_at_done = busy;
    end
    prev_scl_oe = scl_oe;
    prev_sda = ~sda_oe & slave_rel;
  endtask

  // Expected bus bits seen at each SCL rise, busy length and status of one transfer
  task automatic model(input vec_t v, output logic [31:0] w, output int n,
                       output int bcyc, output logic aerr);
    logic rd;
    rd = v.addr[0];
    w = 32'd0; n = 0;
    for (int i = 7; i >= 0; i--) begin w = {w[30:0], v.addr[i]}; n++; end
    w = {w[30:0], ~v.ack_a}; n++;
    if (v.ack_a) begin
      for (int i = 7; i >= 0; i--) begin
        w = {w[30:0], rd ? v.rbyte[i] : v.data[i]}; n++;
      end
      w = {w[30:0], rd ? 1'b1 : ~v.ack_d}; n++;
    end
    w = {w[30:0], 1'b0}; n++;
    bcyc = (v.ack_a ? 80 : 44) * QTR;
    aerr = !v.ack_a || (!rd && !v.ack_d);
    if (v.ack_a && rd) exp_rx = v.rbyte;
  endtask

  task automatic run_xfer(input vec_t v);
    logic [31:0] ew, aw;
    int en, ebusy, n;
    logic eaerr;
    s_ack_a = v.ack_a; s_ack_d = v.ack_d; s_rd = v.addr[0]; s_byte = v.rbyte;
    model(v, ew, en, ebusy, eaerr);
    per_addr = $urandom(); per_addr[7:0] = v.addr;
    per_data = $urandom(); per_data[7:0] = v.data;
    it_enable = v.ien;
    mon_clear();
    startbit = 1'b1;
    step();
    startbit = 1'b0;
    check("busy_rise", 32'(busy), 32'd1);
    check("irq_clr_on_start", 32'(irq), 32'd0);
    check("ack_err_clr_on_start", 32'(ack_err), 32'd0);
    n = 0;
    while (done_cnt == 0 && n < 600) begin
      startbit = v.mid && (n == 100);
      step();
      n++;
    end
    startbit = 1'b0;
    step();
    step();
    aw = 32'd0;
    foreach (bit_q[i]) aw = {aw[30:0], bit_q[i]};
    check("done_count", 32'(done_cnt), 32'd1);
    check("seq_len", 32'(bit_q.size()), 32'(en));
    check("seq_bits", aw, ew);
    check("busy_cycles", 32'(busy_cnt), 32'(ebusy));
    check("busy_low_at_done", 32'(busy_at_done), 32'd0);
    check("ack_err", 32'(ack_err), 32'(eaerr));
    check("rx_data", 32'(rx_data), 32'(exp_rx));
    check("irq_at_done", 32'(irq_at_done), 32'(v.ien));
    check("start_cond", 32'(start_cnt), 32'd1);
    check("stop_cond", 32'(stop_cnt), 32'd1);
    check("lines_idle", 32'({scl_oe, sda_oe}), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_scl_oe"}, 32'(scl_oe), 32'd0);
    check({tag, "_sda_oe"}, 32'(sda_oe), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_ack_err"}, 32'(ack_err), 32'd0);
    check({tag, "_rx_data"}, 32'(rx_data), 32'd0);
    check({tag, "_irq"}, 32'(irq), 32'd0);
  endtask

  initial begin
    vec_t r;
    tbl[0] = '{8'hA0, 8'hA5, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0}; // write, both ACKed
    tbl[1] = '{8'hA1, 8'h00, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0}; // read 0x3C
    tbl[2] = '{8'hA0, 8'h5A, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0}; // address NACK
    tbl[3] = '{8'h3A, 8'hC3, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1}; // data NACK, irq, stray start
    tbl[4] = '{8'hFF, 8'h00, 8'h81, 1'b1, 1'b1, 1'b1, 1'b0}; // read with irq
    tbl[5] = '{8'hE1, 8'h00, 8'h77, 1'b0, 1'b1, 1'b0, 1'b1}; // read address NACK, rx holds

    PRESETn = 1'b0; startbit = 1'b0; resetbit = 1'b0; it_enable = 1'b0;
    per_addr = 32'd0; per_data = 32'd0;
    slave_rel = 1'b1; s_ack_a = 1'b1; s_ack_d = 1'b1; s_rd = 1'b0; s_byte = 8'd0;
    exp_rx = 8'd0;
    #12;
    check_reset_vals("reset");
    @(negedge PCLK);
    PRESETn = 1'b1;
    mon_clear();
    step();

    foreach (tbl[i]) run_xfer(tbl[i]);

    // irq follows it_enable going low
    run_xfer('{8'h20, 8'h11, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0});
    check("irq_held", 32'(irq), 32'd1);
    it_enable = 1'b0;
    step();
    check("irq_ien_drop", 32'(irq), 32'd0);

    // resetbit beats a simultaneous startbit and clears irq/ack_err
    run_xfer('{8'h20, 8'h11, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0});
    resetbit = 1'b1; startbit = 1'b1;
    step();
    resetbit = 1'b0; startbit = 1'b0;
    check("srst_prio_busy", 32'(busy), 32'd0);
    check("srst_irq", 32'(irq), 32'd0);
    check("srst_ack_err", 32'(ack_err), 32'd0);
    step();
    check("srst_prio_busy2", 32'(busy), 32'd0);

    // soft reset at q0 of the fourth DATA bit (data bit 4 of 0xA5 is 0)
    it_enable = 1'b1;
    s_ack_a = 1'b1; s_ack_d = 1'b1; s_rd = 1'b0;
    per_addr = 32'hA0; per_data = 32'hA5;
    mon_clear();
    startbit = 1'b1;
    step();
    startbit = 1'b0;
    for (int i = 0; i < (40 + 12) * QTR; i++) step();
    check("pre_srst_busy", 32'(busy), 32'd1);
    check("pre_srst_lines", 32'({scl_oe, sda_oe}), 32'h3);
    resetbit = 1'b1;
    step();
    resetbit = 1'b0;
    check("srst_lines", 32'({scl_oe, sda_oe}), 32'd0);
    check("srst_busy", 32'(busy), 32'd0);
    check("srst_ack_err2", 32'(ack_err), 32'd0);
    done_cnt = 0;
    for (int i = 0; i < 20; i++) step();
    check("srst_no_done", 32'(done_cnt), 32'd0);
    check("srst_irq2", 32'(irq), 32'd0);
    run_xfer('{8'hA0, 8'hA5, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0});

    // asynchronous reset mid-transfer, between clock edges
    s_ack_a = 1'b1; s_ack_d = 1'b1; s_rd = 1'b0;
    per_addr = 32'h42; per_data = 32'h99; it_enable = 1'b1;
    mon_clear();
    startbit = 1'b1;
    step();
    startbit = 1'b0;
    for (int i = 0; i < 150; i++) step();
    #2 PRESETn = 1'b0;
    #1;
    check_reset_vals("areset");
    exp_rx = 8'd0;
    for (int i = 0; i < 3; i++) step();
    PRESETn = 1'b1;
    mon_clear();
    step();
    run_xfer('{8'hA1, 8'h00, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0});

    // randomized transfers
    for (int k = 0; k < 8; k++) begin
      r.addr  = 8'($urandom());
      r.data  = 8'($urandom());
      r.rbyte = 8'($urandom());
      r.ack_a = ($urandom_range(0, 3) != 0);
      r.ack_d = ($urandom_range(0, 3) != 0);
      r.ien   = 1'($urandom_range(0, 1));
      r.mid   = 1'($urandom_range(0, 1));
      run_xfer(r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
